data_bus_bridge: RTL and testbench

Multi-cycle bridge between the CPU data-access port and an external request/grant data bus. It consumes the same-cycle combinational access produced by the CPU datapath: ALU address, rs2 data, byte/half/word read/write strobes and the load-extension select. It holds the CPU with `stall` until the bus transaction completes, and returns aligned, extended load data on `out_mem`. It does lane steering, byte-strobe generation, misalignment checking and, optionally, a bus watchdog.

---
 rtl/data_bus_bridge.sv | 137 +++++++++++++
 tb/tb_data_bus_bridge.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: multi-cycle bridge from the CPU data port to a request/grant bus.
// Define DATA_BUS_BRIDGE_TIMEOUT_EN to add a watchdog on the REQ and WAIT_R states.
module data_bus_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_mem_1B,
    input  logic        write_mem_2B,
    input  logic        write_mem_4B,
    input  logic        read_mem_1B,
    input  logic        read_mem_2B,
    input  logic        read_mem_4B,
    input  logic        extension_mem,
    output logic [31:0] out_mem,
    output logic        stall,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT_R, DONE, ERR} state_t;
    state_t      state_q;
    logic [1:0]  lane_q, size_q, size_d;
    logic        ext_q, bus_req_q, bus_we_q, mem_err_q;
    logic [31:0] bus_addr_q, bus_wdata_q, out_mem_q, wdata_d, rword_d;
    logic [3:0]  bus_wstrb_q, wstrb_d;
    logic [5:0]  strb;
    logic        acc, multi, mis, is_wr, is2, is4, tmo;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign strb  = {write_mem_1B, write_mem_2B, write_mem_4B, read_mem_1B, read_mem_2B, read_mem_4B};
    assign acc   = |strb;
    assign multi = |(strb & (strb - 6'd1));
    assign is2   = write_mem_2B | read_mem_2B;
    assign is4   = write_mem_4B | read_mem_4B;
    assign is_wr = write_mem_1B | write_mem_2B | write_mem_4B;
    assign mis   = (is2 & address[0]) | (is4 & |address[1:0]);
    assign size_d = is4 ? 2'd2 : is2 ? 2'd1 : 2'd0;
    assign rbyte = bus_rdata[{lane_q, 3'b000} +: 8];
    assign rhalf = bus_rdata[{lane_q[1], 4'b0000} +: 16];

    always_comb begin
        wdata_d = is4 ? write_data : is2 ? {2{write_data[15:0]}} : {4{write_data[7:0]}};
        wstrb_d = !is_wr ? 4'b0000 : is4 ? 4'b1111 :
                  is2 ? 4'b0011 << address[1:0] : 4'b0001 << address[1:0];
        rword_d = size_q == 2'd2 ? bus_rdata :
                  size_q == 2'd1 ? {{16{ext_q & rhalf[15]}}, rhalf} : {{24{ext_q & rbyte[7]}}, rbyte};
        stall   = state_q == IDLE ? acc : (state_q == REQ || state_q == WAIT_R);
    end

`ifdef DATA_BUS_BRIDGE_TIMEOUT_EN
    logic [7:0] cnt_q;
    // Zero in the first REQ cycle, so TIMEOUT counts REQ+WAIT_R cycles exactly.
    assign tmo = cnt_q + 8'd1 == 8'(TIMEOUT);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= 8'd0;
        else      cnt_q <= (state_q == REQ || state_q == WAIT_R) ? cnt_q + 8'd1 : 8'd0;
    end
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lane_q      <= 2'd0;
            size_q      <= 2'd0;
            ext_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_wstrb_q <= 4'd0;
            out_mem_q   <= 32'd0;
            mem_err_q   <= 1'b0;
        end else begin
            mem_err_q <= 1'b0;
            case (state_q)
                IDLE:
                    if (acc && (multi || mis)) begin
                        state_q   <= ERR;
                        mem_err_q <= 1'b1;
                        out_mem_q <= 32'd0;
                    end else if (acc) begin
                        state_q     <= REQ;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= is_wr;
                        bus_addr_q  <= {address[31:2], 2'b00};
                        bus_wdata_q <= wdata_d;
                        bus_wstrb_q <= wstrb_d;
                        lane_q      <= address[1:0];
                        size_q      <= size_d;
                        ext_q       <= extension_mem;
                    end
                REQ:
                    if (bus_gnt) begin
                        bus_req_q <= 1'b0;
                        state_q   <= bus_we_q ? DONE : WAIT_R;
                    end else if (tmo) begin
                        bus_req_q <= 1'b0;
                        state_q   <= ERR;
                        mem_err_q <= 1'b1;
                        out_mem_q <= 32'd0;
                    end
                WAIT_R:
                    if (bus_rvalid) begin
                        out_mem_q <= rword_d;
                        state_q   <= DONE;
                    end else if (tmo) begin
                        state_q   <= ERR;
                        mem_err_q <= 1'b1;
                        out_mem_q <= 32'd0;
                    end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_mem   = out_mem_q;
    assign mem_err   = mem_err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;
endmodule

// File: tb/tb_data_bus_bridge.sv
// tb_data_bus_bridge: directed bench for data_bus_bridge with a scoreboard of expected bus requests and results.
module tb_data_bus_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address = '0, write_data = '0, bus_rdata = '0;
    logic        write_mem_1B = 0, write_mem_2B = 0, write_mem_4B = 0;
    logic        read_mem_1B = 0, read_mem_2B = 0, read_mem_4B = 0;
    logic        extension_mem = 0, bus_gnt = 0, bus_rvalid = 0;
    logic [31:0] out_mem, bus_addr, bus_wdata;
    logic        stall, mem_err, bus_req, bus_we;
    logic [3:0]  bus_wstrb;

    localparam logic [5:0] W1 = 6'b100000, W2 = 6'b010000, W4 = 6'b001000;
    localparam logic [5:0] R1 = 6'b000100, R2 = 6'b000010, R4 = 6'b000001;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        logic        we;
        logic        chk_wd;
    } bus_t;

    bus_t        exp_bus_q[$];
    logic [31:0] exp_out_q[$];
    int          vectors = 0, miscompares = 0;

    data_bus_bridge #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .write_mem_1B(write_mem_1B), .write_mem_2B(write_mem_2B), .write_mem_4B(write_mem_4B),
        .read_mem_1B(read_mem_1B), .read_mem_2B(read_mem_2B), .read_mem_4B(read_mem_4B),
        .extension_mem(extension_mem), .out_mem(out_mem), .stall(stall), .mem_err(mem_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_strobes(input logic [5:0] s);
        {write_mem_1B, write_mem_2B, write_mem_4B, read_mem_1B, read_mem_2B, read_mem_4B} = s;
    endtask

    // Called at a negedge with the bridge idle; returns at a negedge with the bridge idle again.
    task automatic access(input string tag, input logic [5:0] s, input logic [31:0] a, wd,
                          input logic ext, input int gdly, rdly, input logic [31:0] rd,
                          input logic e_req, input bus_t eb_in, input logic [31:0] e_out,
                          input logic e_err, input int e_stall);
        int   stalls = 0, rc = 0, wc = 0;
        bit   fin = 0, granted = 0, seen = 0;
        bus_t eb;
        logic [31:0] eo = '0;
        if (e_req) exp_bus_q.push_back(eb_in);
        exp_out_q.push_back(e_out);
        set_strobes(s);
        address = a; write_data = wd; extension_mem = ext;
        for (int c = 0; c < 300 && !fin; c++) begin
            #1;
            bus_gnt = 0; bus_rvalid = 0;
            if (c > 0 && !stall) begin
                fin = 1;
                eo = exp_out_q.pop_front();
                check({tag, ":out_mem"}, out_mem, eo);
                check({tag, ":mem_err"}, 32'(mem_err), 32'(e_err));
                set_strobes(6'b0);
            end else begin
                if (stall) stalls++;
                if (bus_req) begin
                    if (!seen) begin
                        seen = 1;
                        eb = exp_bus_q.pop_front();
                        check({tag, ":bus_addr"}, bus_addr, eb.addr);
                        check({tag, ":bus_wstrb"}, 32'(bus_wstrb), 32'(eb.strb));
                        check({tag, ":bus_we"}, 32'(bus_we), 32'(eb.we));
                        if (eb.chk_wd) check({tag, ":bus_wdata"}, bus_wdata, eb.wd);
                    end
                    if (rc == gdly) begin bus_gnt = 1; granted = 1; end
                    rc++;
                end else if (granted) begin
                    if (wc == rdly) begin bus_rvalid = 1; bus_rdata = rd; end
                    else bus_rdata = ~rd;
                    wc++;
                end
            end
            @(negedge clk);
        end
        #1;
        check({tag, ":finished"}, 32'(fin), 32'd1);
        check({tag, ":stall_cycles"}, 32'(stalls), 32'(e_stall));
        check({tag, ":req_seen"}, 32'(seen), 32'(e_req));
        check({tag, ":idle_stall"}, 32'(stall), 32'd0);
        check({tag, ":out_hold"}, out_mem, eo);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset:bus_req", 32'(bus_req), 32'd0);
        check("reset:out_mem", out_mem, 32'd0);
        check("reset:mem_err", 32'(mem_err), 32'd0);
        check("reset:bus_addr", bus_addr, 32'd0);
        check("reset:bus_wdata", bus_wdata, 32'd0);
        check("reset:bus_wstrb", 32'(bus_wstrb), 32'd0);
        check("reset:stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        access("sw",   W4, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 1, '{32'h100, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b1}, 32'h0, 0, 2);
        access("sb",   W1, 32'h203, 32'h000000A5, 0, 2, 0, 0, 1, '{32'h200, 32'hA5A5A5A5, 4'b1000, 1'b1, 1'b1}, 32'h0, 0, 4);
        access("sh",   W2, 32'h406, 32'h1234BEEF, 0, 0, 0, 0, 1, '{32'h404, 32'hBEEFBEEF, 4'b1100, 1'b1, 1'b1}, 32'h0, 0, 2);
        access("lb_s", R1, 32'h302, 0, 1, 0, 0, 32'h12F43456, 1, '{32'h300, 32'h0, 4'b0000, 1'b0, 1'b0}, 32'hFFFFFFF4, 0, 3);
        access("lb_u", R1, 32'h302, 0, 0, 0, 0, 32'h12F43456, 1, '{32'h300, 32'h0, 4'b0000, 1'b0, 1'b0}, 32'h000000F4, 0, 3);
        access("lh_w", R2, 32'h402, 0, 1, 3, 1, 32'h8001ABCD, 1, '{32'h400, 32'h0, 4'b0000, 1'b0, 1'b0}, 32'hFFFF8001, 0, 7);
        access("lw",   R4, 32'h504, 0, 1, 0, 0, 32'h89ABCDEF, 1, '{32'h504, 32'h0, 4'b0000, 1'b0, 1'b0}, 32'h89ABCDEF, 0, 3);
        access("lb_p", R1, 32'h901, 0, 1, 1, 0, 32'h00007F00, 1, '{32'h900, 32'h0, 4'b0000, 1'b0, 1'b0}, 32'h0000007F, 0, 4);
        access("lh_u", R2, 32'h600, 0, 0, 0, 0, 32'h1234F00D, 1, '{32'h600, 32'h0, 4'b0000, 1'b0, 1'b0}, 32'h0000F00D, 0, 3);
        access("mis4", R4, 32'h501, 0, 0, 0, 0, 0, 0, '0, 32'h0, 1, 1);
        access("mis2", W2, 32'h403, 32'h1, 0, 0, 0, 0, 0, '0, 32'h0, 1, 1);
        access("lw2",  R4, 32'h700, 0, 0, 0, 0, 32'hCAFEF00D, 1, '{32'h700, 32'h0, 4'b0000, 1'b0, 1'b0}, 32'hCAFEF00D, 0, 3);
        access("multi", R1 | W1, 32'h600, 0, 0, 0, 0, 0, 0, '0, 32'h0, 1, 1);

        access("lw3",  R4, 32'hA00, 0, 0, 0, 0, 32'h0BADCAFE, 1, '{32'hA00, 32'h0, 4'b0000, 1'b0, 1'b0}, 32'h0BADCAFE, 0, 3);
        set_strobes(R4); address = 32'h800;
        @(negedge clk);
        #1;
        check("arst:req_before", 32'(bus_req), 32'd1);
        bus_gnt = 1; bus_rvalid = 1; bus_rdata = 32'hFFFFFFFF;
        #2 rst = 1'b0;
        #1;
        check("arst:bus_req", 32'(bus_req), 32'd0);
        check("arst:out_mem", out_mem, 32'd0);
        check("arst:mem_err", 32'(mem_err), 32'd0);
        set_strobes(6'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("arst:idle_stall", 32'(stall), 32'd0);
        check("arst:idle_req", 32'(bus_req), 32'd0);
        check("arst:rvalid_ignored", out_mem, 32'd0);
        bus_gnt = 0; bus_rvalid = 0;
        @(negedge clk);

`ifdef DATA_BUS_BRIDGE_TIMEOUT_EN
        access("tmo", R4, 32'hB00, 0, 0, 100000, 0, 0, 1, '{32'hB00, 32'h0, 4'b0000, 1'b0, 1'b0}, 32'h0, 1, 9);
        bus_rvalid = 1; bus_rdata = 32'h55555555;
        @(negedge clk);
        #1;
        bus_rvalid = 0;
        check("tmo:late_rvalid", out_mem, 32'd0);
        check("tmo:idle_stall", 32'(stall), 32'd0);
        @(negedge clk);
`endif

        check("sb:bus_q_empty", 32'(exp_bus_q.size()), 32'd0);
        check("sb:out_q_empty", 32'(exp_out_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
